// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the execute stage.
//   ALU operation codes, write-back result-source codes, hazard-unit
//   forward-select codes and the branch funct3 encodings.
package riscv_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_SLTU = 3'b110,
      ALU_SLL  = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational 32-bit ALU for the execute stage.
//   SrcA, SrcB  : operands
//   ALUControl  : operation select (riscv_pkg alu_op_t codes)
//   Result      : operation result
//   Zero        : asserted when Result is all zeros
module alu
   import riscv_pkg::*;
(
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  ALUControl,
   output logic [31:0] Result,
   output logic        Zero
);

   always_comb begin
      Result = '0;
      case (ALUControl)
         ALU_ADD:  Result = SrcA + SrcB;
         ALU_SUB:  Result = SrcA - SrcB;
         ALU_AND:  Result = SrcA & SrcB;
         ALU_OR:   Result = SrcA | SrcB;
         ALU_XOR:  Result = SrcA ^ SrcB;
         ALU_SLT:  Result = {31'b0, ($signed(SrcA) < $signed(SrcB))};
         ALU_SLTU: Result = {31'b0, (SrcA < SrcB)};
         ALU_SLL:  Result = SrcA << SrcB[4:0];
         default:  Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the five-stage RISC-V pipeline.
//   Inputs : ID/EX control (RegWrite_E, ALUSrc_E, MemWrite_E, Branch_E,
//            Jump_E, ResultSrc_E, ALUControl_E, funct3_E), ID/EX operands
//            (RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, RD_E), hazard-unit
//            forward selects (ForwardA_E, ForwardB_E) and ResultW.
//   Outputs: PCSrc_E / PCTarget_E redirect to fetch (combinational) and the
//            EX/MEM register (RegWrite_M, MemWrite_M, ResultSrc_M, RD_M,
//            ALUResult_M, WriteData_M, PCPlus4_M).
//   clk rising edge, rst asynchronous active-high.
module execute_cycle
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_E,
   input  logic        ALUSrc_E,
   input  logic        MemWrite_E,
   input  logic        Branch_E,
   input  logic        Jump_E,
   input  logic [1:0]  ResultSrc_E,
   input  logic [2:0]  ALUControl_E,
   input  logic [2:0]  funct3_E,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   input  logic [31:0] Imm_Ext_E,
   input  logic [31:0] PC_E,
   input  logic [31:0] PCPlus4_E,
   input  logic [4:0]  RD_E,
   input  logic [1:0]  ForwardA_E,
   input  logic [1:0]  ForwardB_E,
   input  logic [31:0] ResultW,
   output logic        PCSrc_E,
   output logic [31:0] PCTarget_E,
   output logic        RegWrite_M,
   output logic        MemWrite_M,
   output logic [1:0]  ResultSrc_M,
   output logic [4:0]  RD_M,
   output logic [31:0] ALUResult_M,
   output logic [31:0] WriteData_M,
   output logic [31:0] PCPlus4_M
);

   logic [31:0] src_a;
   logic [31:0] fwd_b;
   logic [31:0] src_b;
   logic [31:0] alu_result;
   logic        zero;
   logic        taken;

   // Forwarding muxes; select 11 falls back to the register-file value.
   always_comb begin
      src_a = RD1_E;
      case (ForwardA_E)
         FWD_W:   src_a = ResultW;
         FWD_M:   src_a = ALUResult_M;
         default: src_a = RD1_E;
      endcase
   end

   always_comb begin
      fwd_b = RD2_E;
      case (ForwardB_E)
         FWD_W:   fwd_b = ResultW;
         FWD_M:   fwd_b = ALUResult_M;
         default: fwd_b = RD2_E;
      endcase
   end

   // Store data always comes from the forwarded rs2, never the immediate.
   assign src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;

   alu u_alu (
      .SrcA       (src_a),
      .SrcB       (src_b),
      .ALUControl (ALUControl_E),
      .Result     (alu_result),
      .Zero       (zero)
   );

   always_comb begin
      taken = 1'b0;
      case (funct3_E)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         default: taken = 1'b0;
      endcase
   end

   assign PCSrc_E    = Jump_E | (Branch_E & taken);
   assign PCTarget_E = PC_E + Imm_Ext_E;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite_M  <= 1'b0;
         MemWrite_M  <= 1'b0;
         ResultSrc_M <= '0;
         RD_M        <= '0;
         ALUResult_M <= '0;
         WriteData_M <= '0;
         PCPlus4_M   <= '0;
      end else begin
         RegWrite_M  <= RegWrite_E;
         MemWrite_M  <= MemWrite_E;
         ResultSrc_M <= ResultSrc_E;
         RD_M        <= RD_E;
         ALUResult_M <= alu_result;
         WriteData_M <= fwd_b;
         PCPlus4_M   <= PCPlus4_E;
      end
   end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipeline, directly downstream of decode_cycle. It consumes the ID/EX register contents, applies hazard-unit forwarding, runs the ALU, and resolves branches and jumps, returning the redirect to fetch. It registers the results into the EX/MEM pipeline register consumed by the memory stage.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWrite_E, ALUSrc_E, MemWrite_E, Branch_E, Jump_E  in  1 each  control from ID/EX
- ResultSrc_E  in  2  00 ALU, 01 memory, 10 PC+4
- ALUControl_E  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU, 111 SLL
- funct3_E  in  3  branch-condition select
- RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E  in  32 each  ID/EX operands
- RD_E  in  5  destination register
- ForwardA_E, ForwardB_E  in  2 each  from hazard unit: 00 register file, 01 ResultW, 10 ALUResult_M
- ResultW  in  32  write-back value
- PCSrc_E  out  1  redirect fetch (combinational)
- PCTarget_E  out  32  redirect address (combinational)
- RegWrite_M, MemWrite_M  out  1 each  registered
- ResultSrc_M  out  2  registered
- RD_M  out  5  registered
- ALUResult_M, WriteData_M, PCPlus4_M  out  32 each  registered

## Operation
- SrcA: ForwardA_E 00→RD1_E, 01→ResultW, 10→ALUResult_M (the registered output, fed back internally), 11→RD1_E.
- FwdB: the same mux on RD2_E. SrcB = ALUSrc_E ? Imm_Ext_E : FwdB. WriteData = FwdB (always the forwarded rs2, never the immediate).
- ALU: ADD and SUB wrap modulo 2^32. AND, OR, XOR are bitwise. SLT is a signed compare and SLTU an unsigned compare; both produce 32'h1 or 32'h0. SLL = SrcA << SrcB[4:0], upper bits of SrcB ignored.
- Zero = (ALUResult == 0).
- Branch condition from funct3_E: 000 (BEQ) taken if Zero; 001 (BNE) taken if !Zero; all other encodings not taken.
- PCSrc_E = Jump_E | (Branch_E & taken).
- PCTarget_E = PC_E + Imm_Ext_E, 32-bit wrap. Valid whenever PCSrc_E=1.
- A flushed ID/EX bubble (all zeros) must produce PCSrc_E=0, RegWrite_M=0 and MemWrite_M=0 on the next edge.
- Both forward selects active at once: each mux is independent. Priority between M and W is owned by the hazard unit.

## Timing
- ALU, forwarding, PCSrc_E and PCTarget_E are combinational from stage inputs, with zero-cycle latency to the redirect.
- EX/MEM register: one cycle latency. Every rising clk edge captures {RegWrite, MemWrite, ResultSrc, RD, ALUResult, WriteData, PCPlus4}.
- No stall or flush on EX/MEM; it updates every cycle.
- Reset: asynchronous assert clears all registered outputs to 0 immediately, so ALUResult_M=0 and the forwarding path reads 0. Release takes effect at the next edge.
- Reset asserted mid-instruction discards the in-flight EX/MEM contents with no partial update.
- PCSrc_E is not gated by rst; the upstream ID/EX register is already zero under reset.

## Structure
- Shared package riscv_pkg holds:
  - ALU control codes (ALU_ADD…ALU_SLL)
  - ResultSrc codes
  - forward-select codes (FWD_RF, FWD_W, FWD_M)
  - branch funct3 codes (F3_BEQ, F3_BNE)
- One sub-module, alu: inputs SrcA, SrcB, ALUControl; outputs Result and Zero; purely combinational.
- The EX/MEM register, forwarding muxes and branch logic stay in execute_cycle.

## Test plan
- ADD, no forwarding: RD1_E=5, RD2_E=7, ALUControl 000, ALUSrc_E=0, RegWrite_E=1, RD_E=3 → after one edge ALUResult_M=12, RD_M=3, RegWrite_M=1.
- Back-to-back forwarding from M: cycle 1 computes 12. Cycle 2 sets ForwardA_E=10, RD1_E=0, Imm=1, ALUSrc_E=1 → ALUResult_M=13. Repeat with ForwardB_E=01, ResultW=100, SUB, RD1_E=150 → 50.
- BEQ taken: RD1_E=RD2_E=9, Branch_E=1, funct3 000, SUB, PC_E=0x40, Imm=-8 → PCSrc_E=1, PCTarget_E=0x38. Same with funct3 001 → PCSrc_E=0.
- JAL: Jump_E=1, PC_E=0x100, Imm=0x20, PCPlus4_E=0x104, ResultSrc_E=10 → PCSrc_E=1, PCTarget_E=0x120, next edge PCPlus4_M=0x104, ResultSrc_M=10.
- ALU corners:
  - SLT with 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0.
  - SLL of 1 by SrcB=0x21 → 2.
  - ADD 0xFFFFFFFF+1 → 0 with Zero=1.
  - SW: WriteData_M=FwdB while SrcB is the immediate.
- Async reset mid-stream: assert rst between edges → all *_M outputs 0 immediately. After release, the first edge captures the current inputs normally.
